sysreg_access_ctrl: RTL and testbench
=====================================

// Module: sysreg_access_ctrl
// PURPOSE
//  Sits between the core execute stage and the star-topology system-register bus;
//  drives that bus's rd_*/wr_* inputs and consumes its rd_valid/rd_val.
//  Accepts one sysreg read/write request at a time and checks privilege.
//  Issues a single-cycle bus strobe and waits for read data under a timeout.
//  Returns data or a fault code to writeback via a valid/ready response port.
// PARAMETERS
//  TAG_W          4   width of request/response tag
//  PRIV_GROUP_MIN 8   groups >= this value require plevel==0
//  TIMEOUT        15  max WAIT cycles for rd_valid (>=2)
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous, active-high
//  flush       in   1      pipeline flush; abandons in-flight request
//  req_valid   in   1      request valid
//  req_ready   out  1      request accepted when valid&&ready
//  req_write   in   1      1=write, 0=read
//  req_group   in   5      register group
//  req_regnum  in   3      register number within group
//  req_plevel  in   2      requester privilege level (0=highest)
//  req_wdata   in   64     write data
//  req_tag     in   TAG_W  tag echoed on response
//  rd_en       out  1      bus read strobe (one cycle)
//  rd_group/rd_regnum/rd_plevel  out 5/3/2  bus read address/privilege
//  rd_valid    in   1      bus read data valid
//  rd_val      in   64     bus read data
//  wr_en       out  1      bus write strobe (one cycle)
//  wr_group/wr_regnum/wr_plevel  out 5/3/2  bus write address/privilege
//  wr_val      out  64     bus write data
//  resp_valid  out  1      response valid, held until resp_ready
//  resp_ready  in   1      response consumer ready
//  resp_data   out  64     read data (0 for writes and faults)
//  resp_tag    out  TAG_W  tag of the completed request
//  resp_fault  out  2      0=ok, 1=privilege, 2=timeout, 3=reserved
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready=1; rd_en=wr_en=resp_valid=0; captured fields,
//    resp_data/tag/fault and counter = 0.
//  - States: IDLE, ISSUE, WAIT, RESP, DRAIN. req_ready = (state==IDLE) && !flush.
//  - IDLE: on accept, capture all req_* fields. Privilege fault when
//    group>=PRIV_GROUP_MIN && plevel!=0:
//    -> RESP with fault=1, and no bus strobe is ever issued; else -> ISSUE.
//  - ISSUE (1 cycle): read drives rd_en=1 plus rd_* fields -> WAIT, cnt=0.
//    Write drives wr_en=1 plus wr_* fields -> RESP with fault=0.
//    Address/data outputs are don't-care outside strobe cycles but hold the captured values.
//  - WAIT: rd_valid -> register rd_val into resp_data, fault=0 -> RESP.
//    Else if cnt==TIMEOUT-1 -> RESP with fault=2, data=0. Else cnt++.
//    rd_valid is never sampled in ISSUE.
//  - RESP: resp_valid=1, and data/tag/fault are stable while stalled.
//    On resp_ready -> IDLE; the next request is accepted no earlier than the following cycle.
//  - DRAIN: req_ready=0. Exits to IDLE on rd_valid (data discarded) or
//    when cnt==TIMEOUT-1. This prevents a late read being attributed to the next request.
//  - flush:
//    - IDLE: blocks acceptance.
//    - ISSUE: suppresses the strobe (rd_en/wr_en forced 0) -> IDLE.
//    - WAIT: -> DRAIN, cnt continues.
//    - RESP: drops the response -> IDLE.
//    - DRAIN: no effect.
//    flush has priority over rd_valid and timeout in the same cycle.
//  - rd_valid in IDLE/ISSUE/RESP is ignored.
//  - Latency, accept at cycle T:
//    - write: wr_en at T+1, resp_valid at T+2.
//    - read: rd_en at T+1; rd_valid at T+k (k>=2) gives resp_valid at T+k+1.
//  - rst mid-operation: returns to reset state next cycle. No strobe or response is emitted
//    in the cycle after rst is sampled.
// TESTING
//  - Write grp3/reg1/pl2, data 0xDEAD_BEEF, tag 5: wr_en at T+1 with those values;
//    resp at T+2 with fault=0, tag=5, data=0.
//  - Read grp10/reg7/pl0; bus returns rd_val=0x1234 three cycles after rd_en:
//    resp_data=0x1234, fault=0, resp_valid on the cycle after rd_valid.
//  - Read grp10/pl1: no rd_en ever; resp fault=1 at T+1, data=0.
//  - Read with no rd_valid: resp fault=2 after TIMEOUT(15) WAIT cycles.
//    Hold resp_ready=0 for 4 cycles: outputs stable, req_ready=0.
//  - flush 1 cycle after rd_en, late rd_valid 5 cycles later: no response,
//    req_ready=0 until that rd_valid; the next read returns its own data.
//  - Back-to-back writes with resp_ready=1: one accept every 3 cycles, strobes 3 cycles apart;
//    rst asserted in ISSUE gives no strobe and an IDLE state.

Source files
------------

// File: rtl/sysreg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sysreg_access_ctrl
// Description : Single-outstanding system-register access controller. Checks
//               privilege, issues one-cycle read/write strobes to the sysreg
//               bus, waits for read data under a timeout and returns data or a
//               fault code on a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module sysreg_access_ctrl #(
    parameter int TAG_W          = 4,
    parameter int PRIV_GROUP_MIN = 8,
    parameter int TIMEOUT        = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    // request from execute
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [4:0]       req_group,
    input  logic [2:0]       req_regnum,
    input  logic [1:0]       req_plevel,
    input  logic [63:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    // sysreg bus read side
    output logic             rd_en,
    output logic [4:0]       rd_group,
    output logic [2:0]       rd_regnum,
    output logic [1:0]       rd_plevel,
    input  logic             rd_valid,
    input  logic [63:0]      rd_val,
    // sysreg bus write side
    output logic             wr_en,
    output logic [4:0]       wr_group,
    output logic [2:0]       wr_regnum,
    output logic [1:0]       wr_plevel,
    output logic [63:0]      wr_val,
    // response to writeback
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic [1:0]       resp_fault
);

    // Counter must also hold TIMEOUT itself: a flush in the last WAIT cycle
    // bumps it one past the limit on the way into DRAIN.
    localparam int c_CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [4:0]         c_PRIV_MIN = 5'(PRIV_GROUP_MIN);

    localparam logic [1:0] c_FAULT_OK   = 2'd0;
    localparam logic [1:0] c_FAULT_PRIV = 2'd1;
    localparam logic [1:0] c_FAULT_TMO  = 2'd2;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WAIT  = 3'd2;
    localparam logic [2:0] c_RESP  = 3'd3;
    localparam logic [2:0] c_DRAIN = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_write;
    logic [4:0]         r_group;
    logic [2:0]         r_regnum;
    logic [1:0]         r_plevel;
    logic [63:0]        r_wdata;
    logic [TAG_W-1:0]   r_tag;
    logic [c_CNT_W-1:0] r_cnt;
    logic [63:0]        r_resp_data;
    logic [1:0]         r_resp_fault;

    logic w_accept;
    logic w_priv_fault;
    logic w_cnt_last;
    logic w_drain_done;

    assign req_ready    = (r_state == c_IDLE) && !flush;
    assign w_accept     = req_valid && req_ready;
    assign w_priv_fault = (req_group >= c_PRIV_MIN) && (req_plevel != 2'd0);
    assign w_cnt_last   = (r_cnt == c_CNT_LAST);
    assign w_drain_done = rd_valid || (r_cnt >= c_CNT_LAST);

    // Strobes are gated by flush and by rst so an abandoned or reset ISSUE
    // cycle never reaches the bus.
    assign rd_en = (r_state == c_ISSUE) && !r_write && !flush && !rst;
    assign wr_en = (r_state == c_ISSUE) &&  r_write && !flush && !rst;

    assign rd_group   = r_group;
    assign rd_regnum  = r_regnum;
    assign rd_plevel  = r_plevel;
    assign wr_group   = r_group;
    assign wr_regnum  = r_regnum;
    assign wr_plevel  = r_plevel;
    assign wr_val     = r_wdata;

    assign resp_valid = (r_state == c_RESP);
    assign resp_data  = r_resp_data;
    assign resp_tag   = r_tag;
    assign resp_fault = r_resp_fault;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; flush outranks rd_valid and timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_priv_fault ? c_RESP : c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (flush) begin
                    w_state_nxt = c_IDLE;
                end else if (r_write) begin
                    w_state_nxt = c_RESP;
                end else begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                if (flush) begin
                    w_state_nxt = c_DRAIN;
                end else if (rd_valid || w_cnt_last) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_RESP: begin
                if (flush || resp_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Request capture, wait counter and response payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_write      <= 1'b0;
            r_group      <= '0;
            r_regnum     <= '0;
            r_plevel     <= '0;
            r_wdata      <= '0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_resp_data  <= '0;
            r_resp_fault <= c_FAULT_OK;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_write      <= req_write;
                        r_group      <= req_group;
                        r_regnum     <= req_regnum;
                        r_plevel     <= req_plevel;
                        r_wdata      <= req_wdata;
                        r_tag        <= req_tag;
                        r_resp_data  <= '0;
                        r_resp_fault <= w_priv_fault ? c_FAULT_PRIV : c_FAULT_OK;
                    end
                end
                c_ISSUE: begin
                    r_cnt <= '0;
                end
                c_WAIT: begin
                    if (flush) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (rd_valid) begin
                        r_resp_data  <= rd_val;
                        r_resp_fault <= c_FAULT_OK;
                    end else if (w_cnt_last) begin
                        r_resp_data  <= '0;
                        r_resp_fault <= c_FAULT_TMO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_DRAIN: begin
                    if (!w_drain_done) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sysreg_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sysreg_access_ctrl
// Description : Self-checking bench for sysreg_access_ctrl. Expected responses
//               are queued when a request is driven and compared when the DUT
//               hands a response over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysreg_access_ctrl;

    localparam int TAG_W = 4;

    typedef struct {
        logic [63:0]      data;
        logic [TAG_W-1:0] tag;
        logic [1:0]       fault;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [4:0]       req_group = '0;
    logic [2:0]       req_regnum = '0;
    logic [1:0]       req_plevel = '0;
    logic [63:0]      req_wdata = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             rd_en;
    logic [4:0]       rd_group;
    logic [2:0]       rd_regnum;
    logic [1:0]       rd_plevel;
    logic             rd_valid = 1'b0;
    logic [63:0]      rd_val = '0;
    logic             wr_en;
    logic [4:0]       wr_group;
    logic [2:0]       wr_regnum;
    logic [1:0]       wr_plevel;
    logic [63:0]      wr_val;
    logic             resp_valid;
    logic             resp_ready = 1'b1;
    logic [63:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic [1:0]       resp_fault;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_rd     = 0;
    resp_t sb_q[$];

    sysreg_access_ctrl #(.TAG_W(TAG_W), .PRIV_GROUP_MIN(8), .TIMEOUT(15)) u_dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_group(req_group), .req_regnum(req_regnum), .req_plevel(req_plevel),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rd_en(rd_en), .rd_group(rd_group), .rd_regnum(rd_regnum),
        .rd_plevel(rd_plevel), .rd_valid(rd_valid), .rd_val(rd_val),
        .wr_en(wr_en), .wr_group(wr_group), .wr_regnum(wr_regnum),
        .wr_plevel(wr_plevel), .wr_val(wr_val),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_tag(resp_tag), .resp_fault(resp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait (bounded) for acceptance; returns in cycle T+1.
    task automatic issue_req(input logic wr, input logic [4:0] grp, input logic [2:0] rn,
                             input logic [1:0] pl, input logic [63:0] wd,
                             input logic [TAG_W-1:0] tg);
        int waited;
        req_valid = 1'b1; req_write = wr; req_group = grp; req_regnum = rn;
        req_plevel = pl;  req_wdata = wd; req_tag = tg;
        waited = 0;
        #1;
        while (!req_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!req_ready) check("req_ready_timeout", 64'd0, 64'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Scoreboard: compare each handed-over response with the queued expectation.
    always @(negedge clk) begin
        if (rd_en) n_rd++;
        if (!rst && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_resp", 64'd1, 64'd0);
            end else begin
                resp_t e;
                e = sb_q.pop_front();
                check("resp_data",  resp_data,  e.data);
                check("resp_tag",   64'(resp_tag),   64'(e.tag));
                check("resp_fault", 64'(resp_fault), 64'(e.fault));
            end
        end
    end

    initial begin
        int rd_before;

        // ---- reset state ----
        repeat (3) tick();
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_rd_en",      64'(rd_en),      64'd0);
        check("rst_wr_en",      64'(wr_en),      64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data",  resp_data,       64'd0);
        check("rst_resp_tag",   64'(resp_tag),   64'd0);
        check("rst_resp_fault", 64'(resp_fault), 64'd0);
        rst = 1'b0;
        tick();

        // ---- write grp3/reg1/pl2 ----
        sb_q.push_back('{data: 64'd0, tag: 4'd5, fault: 2'd0});
        issue_req(1'b1, 5'd3, 3'd1, 2'd2, 64'hDEAD_BEEF, 4'd5);
        check("wr_en_t1",     64'(wr_en),     64'd1);
        check("wr_rd_en_t1",  64'(rd_en),     64'd0);
        check("wr_group",     64'(wr_group),  64'd3);
        check("wr_regnum",    64'(wr_regnum), 64'd1);
        check("wr_plevel",    64'(wr_plevel), 64'd2);
        check("wr_val",       wr_val,         64'hDEAD_BEEF);
        check("wr_resp_t1",   64'(resp_valid), 64'd0);
        tick();
        check("wr_resp_t2",   64'(resp_valid), 64'd1);
        check("wr_en_t2",     64'(wr_en),      64'd0);
        tick();
        check("wr_idle_ready", 64'(req_ready), 64'd1);

        // ---- read grp10/reg7/pl0, data three cycles after rd_en ----
        sb_q.push_back('{data: 64'h1234, tag: 4'd2, fault: 2'd0});
        issue_req(1'b0, 5'd10, 3'd7, 2'd0, 64'd0, 4'd2);
        check("rd_en_t1",   64'(rd_en),     64'd1);
        check("rd_group",   64'(rd_group),  64'd10);
        check("rd_regnum",  64'(rd_regnum), 64'd7);
        check("rd_plevel",  64'(rd_plevel), 64'd0);
        tick();
        check("rd_en_t2", 64'(rd_en), 64'd0);
        tick();
        tick();
        rd_valid = 1'b1; rd_val = 64'h1234;
        #1;
        check("rd_resp_early", 64'(resp_valid), 64'd0);
        tick();
        rd_valid = 1'b0; rd_val = 64'hFFFF_0000_FFFF_0000;
        check("rd_resp_valid", 64'(resp_valid), 64'd1);
        tick();

        // ---- privilege fault: grp10/pl1, no strobe ----
        rd_before = n_rd;
        sb_q.push_back('{data: 64'd0, tag: 4'd3, fault: 2'd1});
        issue_req(1'b0, 5'd10, 3'd0, 2'd1, 64'd0, 4'd3);
        check("priv_resp_t1", 64'(resp_valid), 64'd1);
        check("priv_rd_en",   64'(rd_en),      64'd0);
        tick();
        tick();
        check("priv_no_strobe", 64'(n_rd - rd_before), 64'd0);

        // ---- timeout, then 4 stalled cycles ----
        resp_ready = 1'b0;
        sb_q.push_back('{data: 64'd0, tag: 4'd4, fault: 2'd2});
        issue_req(1'b0, 5'd4, 3'd0, 2'd3, 64'd0, 4'd4);
        check("tmo_rd_en", 64'(rd_en), 64'd1);
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 14) check("tmo_not_early", 64'(resp_valid), 64'd0);
        end
        tick();
        check("tmo_resp_valid", 64'(resp_valid), 64'd1);
        req_valid = 1'b1; req_write = 1'b1; req_tag = 4'd15;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("stall_valid", 64'(resp_valid), 64'd1);
            check("stall_fault", 64'(resp_fault), 64'd2);
            check("stall_data",  resp_data,       64'd0);
            check("stall_tag",   64'(resp_tag),   64'd4);
            check("stall_ready", 64'(req_ready),  64'd0);
            tick();
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        tick();

        // ---- flush in WAIT, late rd_valid, then a clean read ----
        issue_req(1'b0, 5'd2, 3'd3, 2'd0, 64'd0, 4'd6);
        check("fl_rd_en", 64'(rd_en), 64'd1);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_ready", 64'(req_ready),  64'd0);
            check("drain_resp",  64'(resp_valid), 64'd0);
            tick();
        end
        rd_valid = 1'b1; rd_val = 64'hBAD0_BAD0;
        #1;
        check("drain_ready_last", 64'(req_ready), 64'd0);
        tick();
        rd_valid = 1'b0;
        check("drain_exit_ready", 64'(req_ready),  64'd1);
        check("drain_exit_resp",  64'(resp_valid), 64'd0);
        sb_q.push_back('{data: 64'h5555, tag: 4'd7, fault: 2'd0});
        issue_req(1'b0, 5'd2, 3'd4, 2'd0, 64'd0, 4'd7);
        tick();
        rd_valid = 1'b1; rd_val = 64'h5555;
        tick();
        rd_valid = 1'b0;
        check("fl_next_resp", 64'(resp_valid), 64'd1);
        tick();

        // ---- back-to-back writes, req_valid held ----
        req_valid = 1'b1; req_write = 1'b1; req_group = 5'd1; req_regnum = 3'd2;
        req_plevel = 2'd0; req_wdata = 64'd100; req_tag = 4'd8;
        for (int c = 0; c < 9; c++) begin
            #1;
            case (c % 3)
                0: begin
                    check("b2b_accept", 64'(req_ready), 64'd1);
                    sb_q.push_back('{data: 64'd0, tag: req_tag, fault: 2'd0});
                end
                1: begin
                    check("b2b_wr_en",  64'(wr_en),    64'd1);
                    check("b2b_wr_val", wr_val,        64'(100 + c / 3));
                    check("b2b_busy",   64'(req_ready), 64'd0);
                end
                default: check("b2b_resp", 64'(resp_valid), 64'd1);
            endcase
            tick();
            if (c % 3 == 0) begin
                req_wdata = req_wdata + 64'd1;
                req_tag   = req_tag + 4'd1;
                if (c == 6) req_valid = 1'b0;
            end
        end

        // ---- rst during ISSUE ----
        issue_req(1'b1, 5'd6, 3'd5, 2'd1, 64'hCAFE, 4'd11);
        rst = 1'b1;
        #1;
        check("rst_issue_wr_en", 64'(wr_en), 64'd0);
        tick();
        rst = 1'b0;
        check("rst_issue_wr_en_after", 64'(wr_en),      64'd0);
        check("rst_issue_resp",        64'(resp_valid), 64'd0);
        check("rst_issue_ready",       64'(req_ready),  64'd1);
        tick();
        check("rst_issue_resp2", 64'(resp_valid), 64'd0);
        tick();

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
